// File: rtl/l2_xbar_pkg.sv
// Shared helpers for the L2 crossbar schedulers.
//   cnt_width     : width of an in-flight counter able to hold 0..max_out
//   onehot_to_idx : index of the (highest) set bit of a one-hot vector
package l2_xbar_pkg;

    localparam int unsigned ONEHOT_MAX_W = 64;

    // Counter width rule: $clog2(MAX_OUTSTANDING+1)
    function automatic int unsigned cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    function automatic int unsigned onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ONEHOT_MAX_W; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/l2_rr_prio_select.sv
// Rotating find-first-set: returns the first asserted req at or above ptr,
// wrapping modulo N.
//   req   : request vector
//   ptr   : highest-priority index (must be < N)
//   idx   : selected index
//   valid : any request asserted
module l2_rr_prio_select
    import l2_xbar_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] sum;

    // Rotate so that bit 0 of rot corresponds to req[ptr]
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N-1:0];

    always_comb begin
        valid = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
            end
        end
        idx = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
    end

endmodule

// File: rtl/l2_ch_rr_scheduler.sv
// Round-robin scheduler sharing one L2 port among N_MASTER requesters with an
// outstanding-transaction limit and one-hot response ID decode.
//   data_*_i (master side) : per-master request + payload, flattened
//   data_gnt_o             : per-master grant (combinational)
//   data_*_o (memory side) : selected request, payload, one-hot ID
//   data_gnt_i             : memory grant
//   data_r_valid_i/_r_ID_i : response strobe and one-hot ID
//   data_r_valid_o         : per-master response valid (combinational)
//   outstanding_o          : in-flight count
//   err_o                  : sticky response-underflow flag
module l2_ch_rr_scheduler
    import l2_xbar_pkg::*;
#(
    parameter  int unsigned N_MASTER        = 16,
    parameter  int unsigned ADDR_WIDTH      = 32,
    parameter  int unsigned DATA_WIDTH      = 64,
    parameter  int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter  int unsigned TAG_WIDTH       = BE_WIDTH,
    parameter  int unsigned ID_WIDTH        = N_MASTER,
    parameter  int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTER-1:0]              data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0]   data_add_i,
    input  logic [N_MASTER-1:0]              data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [N_MASTER*TAG_WIDTH-1:0]    data_wtag_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]     data_be_i,
    output logic [N_MASTER-1:0]              data_gnt_o,
    output logic                             data_req_o,
    output logic [ADDR_WIDTH-1:0]            data_add_o,
    output logic                             data_wen_o,
    output logic [DATA_WIDTH-1:0]            data_wdata_o,
    output logic [TAG_WIDTH-1:0]             data_wtag_o,
    output logic [BE_WIDTH-1:0]              data_be_o,
    output logic [ID_WIDTH-1:0]              data_ID_o,
    input  logic                             data_gnt_i,
    input  logic                             data_r_valid_i,
    input  logic [ID_WIDTH-1:0]              data_r_ID_i,
    output logic [N_MASTER-1:0]              data_r_valid_o,
    output logic [CNT_W-1:0]                 outstanding_o,
    output logic                             err_o
);

    localparam int unsigned      IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_MASTER - 1);

    logic [IDX_W-1:0] rr_ptr, lock_idx, sel_idx, winner;
    logic             locked, err, sel_valid, full, hs;
    logic [CNT_W-1:0] cnt;

    l2_rr_prio_select #(.N(N_MASTER)) u_sel (
        .req   (data_req_i),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Full uses the registered count only; a same-cycle response does not bypass it
    assign full       = (cnt == CNT_W'(MAX_OUTSTANDING));
    assign winner     = locked ? lock_idx : sel_idx;
    assign data_req_o = (locked | sel_valid) & ~full;
    assign hs         = data_req_o & data_gnt_i;

    // Payload mux, ID and grant decode; everything zero while no request is issued
    always_comb begin
        data_add_o   = '0;
        data_wen_o   = 1'b0;
        data_wdata_o = '0;
        data_wtag_o  = '0;
        data_be_o    = '0;
        data_ID_o    = '0;
        data_gnt_o   = '0;
        if (data_req_o) begin
            for (int m = 0; m < N_MASTER; m++) begin
                if (winner == IDX_W'(m)) begin
                    data_add_o    = data_add_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                    data_wen_o    = data_wen_i[m];
                    data_wdata_o  = data_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
                    data_wtag_o   = data_wtag_i[m*TAG_WIDTH +: TAG_WIDTH];
                    data_be_o     = data_be_i[m*BE_WIDTH +: BE_WIDTH];
                    data_ID_o[m]  = 1'b1;
                    data_gnt_o[m] = data_gnt_i;
                end
            end
        end
    end

    assign data_r_valid_o = {N_MASTER{data_r_valid_i}} & data_r_ID_i[N_MASTER-1:0];
    assign outstanding_o  = cnt;
    assign err_o          = err;

    // Pointer, selection lock, in-flight counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            lock_idx <= '0;
            locked   <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            if (hs) begin
                rr_ptr <= (winner == LAST) ? '0 : winner + IDX_W'(1);
                locked <= 1'b0;
            end else if (data_req_o) begin
                // Hold the selection stable until the memory grants it
                locked   <= 1'b1;
                lock_idx <= winner;
            end
            case ({hs, data_r_valid_i})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   if (cnt != '0) cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
            if (data_r_valid_i && (cnt == '0)) err <= 1'b1;
        end
    end

endmodule

// File: doc/l2_ch_rr_scheduler.md
# l2_ch_rr_scheduler

Round-robin scheduler that shares one L2 memory port between N_MASTER requesters, and bounds the number of in-flight transactions. It sits between the master-side request ports and the single-channel L2 memory interface. It replaces a stateless arbitration tree wherever fairness, request stability under back-pressure and an outstanding-transaction limit are required. It also decodes the one-hot response ID back into per-master valid strobes.

## Interface
- N_MASTER, 16: number of requesters; any value ≥ 2, not necessarily a power of 2.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 64: write data width.
- BE_WIDTH, DATA_WIDTH/8: byte-enable width.
- TAG_WIDTH, BE_WIDTH: write-tag width.
- ID_WIDTH, N_MASTER: one-hot transaction ID width.
- MAX_OUTSTANDING, 8: maximum number of granted transactions without a response; must be ≥ 1.
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- data_req_i  in  N_MASTER  per-master request.
- data_add_i  in  N_MASTER×ADDR_WIDTH  per-master address.
- data_wen_i  in  N_MASTER  per-master write enable; 1 means read.
- data_wdata_i  in  N_MASTER×DATA_WIDTH  per-master write data.
- data_wtag_i  in  N_MASTER×TAG_WIDTH  per-master write tag.
- data_be_i  in  N_MASTER×BE_WIDTH  per-master byte enables.
- data_gnt_o  out  N_MASTER  per-master grant.
- data_req_o  out  1  request to memory.
- data_add_o, data_wen_o, data_wdata_o, data_wtag_o, data_be_o  out  as above  payload of the selected master.
- data_ID_o  out  ID_WIDTH  one-hot ID of the selected master.
- data_gnt_i  in  1  memory grant.
- data_r_valid_i  in  1  response valid; exactly one response per granted transaction, reads and writes alike.
- data_r_ID_i  in  ID_WIDTH  one-hot ID of the response.
- data_r_valid_o  out  N_MASTER  per-master response valid.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
- err_o  out  1  sticky flag: a response arrived while the in-flight count was 0.

## Operation
- State: rr_ptr (index of the highest-priority master), cnt (in-flight count), locked/lock_idx (selection hold), err.
- full = (cnt == MAX_OUTSTANDING). The check uses the registered count only; a response in the same cycle does not bypass it.
- Winner selection:
  - If locked, the winner is lock_idx.
  - Otherwise the winner is the first asserted data_req_i at or above rr_ptr, wrapping modulo N_MASTER.
- data_req_o = (locked or any data_req_i) and !full.
- The payload outputs carry the winner's fields. data_ID_o has bit [winner] set and all other bits 0.
- When data_req_o is 0, the payload outputs are 0.
- data_gnt_o[winner] = data_req_o & data_gnt_i. All other grant bits are 0.
- Handshake is data_req_o & data_gnt_i. On a handshake:
  - rr_ptr <= (winner+1) mod N_MASTER;
  - locked <= 0.
- If data_req_o=1 and data_gnt_i=0: locked <= 1 and lock_idx <= winner. The selection then holds until granted.
- Masters keep data_req_i and the payload stable until granted; this is the protocol and is not checked.
- Counter updates:
  - handshake only: cnt+1;
  - response only: cnt−1;
  - both in the same cycle: cnt unchanged.
- A response with cnt=0: cnt stays 0 and err <= 1. err is cleared only by reset.
- data_r_valid_o[i] = data_r_valid_i & data_r_ID_i[i]. This is combinational and independent of cnt.
- While full, the lock is still held, but data_req_o is low.

## Timing
- Paths from data_req_i and payload to the outputs are combinational, zero cycles.
- The data_gnt_i → data_gnt_o path is combinational.
- The response path is combinational.
- rr_ptr, cnt, lock and err update on the rising clk edge after the event.
- A new winner can be selected every cycle, giving a throughput of 1 transaction per cycle while cnt < MAX_OUTSTANDING.
- Reset values:
  - rr_ptr=0, cnt=0, locked=0, err=0;
  - data_req_o=0 with no requests, and data_gnt_o=0;
  - outstanding_o=0, err_o=0.
- Reset asserted mid-operation: all state clears immediately (asynchronously). In-flight responses arriving after reset raise err_o.

## Structure
- Shared package l2_xbar_pkg holds:
  - the function onehot_to_idx;
  - the localparam CNT_W rule $clog2(MAX_OUTSTANDING+1).
- One sub-module: l2_rr_prio_select, a combinational find-first-set rotated by a pointer.
  - Inputs: req vector, ptr.
  - Outputs: idx, valid.
  - It is reused by the other L2 schedulers.
- Top level holds the registers, payload mux, grant decode and response decode.

## Test plan
- N_MASTER=4, reqs 0,1,3 held high, data_gnt_i=1 constant → grants in order 0,1,3,0,1,3. data_ID_o is 0001, 0010, 1000 respectively.
- rr_ptr=0, req[0] high, data_gnt_i=0 for 3 cycles, then req[2] rises → data_add_o stays at master 0's address. The first grant goes to 0, the next to 2.
- MAX_OUTSTANDING=2, no responses, continuous requests → 2 handshakes, then data_req_o=0 and outstanding_o=2. One response → outstanding_o=1 and data_req_o=1 on the next cycle.
- Handshake and data_r_valid_i in the same cycle with cnt=1 → cnt remains 1. data_r_valid_o equals data_r_ID_i.
- data_r_valid_i with cnt=0 → err_o=1 from the next cycle, outstanding_o=0. err_o stays set until rst_n=0.
- N_MASTER=3 (non power of 2), winner 2 granted → rr_ptr wraps to 0. Reset mid-stream → all outputs return to their reset values within the same cycle.
